data_mem_ctrl: RTL and testbench

//  Data-memory responder for the CPU load/store path. Consumes mem_rd/mem_wr

---
 rtl/data_mem_ctrl_if.sv | 24 ++
 rtl/data_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Load/store bus between the CPU execute stage and the data-memory responder.
// Latency: none, wires only.
// Backpressure: responder raises stall_o until the pending access completes.
interface data_mem_ctrl_if;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        fault_o;

  modport master (
    output mem_rd_i, mem_wr_i, funct3_i, addr_i, wdata_i,
    input  rdata_o, stall_o, done_o, fault_o
  );

  modport slave (
    input  mem_rd_i, mem_wr_i, funct3_i, addr_i, wdata_i,
    output rdata_o, stall_o, done_o, fault_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: byte/half/word loads and stores on an internal word array.
// Latency: request in IDLE at cycle t -> done_o/fault_o pulse at t+1+LATENCY.
// Backpressure: stall_o holds the pipeline from the request cycle until DONE.
module data_mem_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  data_mem_ctrl_if.slave bus
);

  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW       = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam bit ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [2:0]      r_funct3;
  logic            r_wr;
  logic            r_fault;
  logic [31:0]     r_rdata;
  logic            r_done;
  logic            r_fault_p;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_in_fault;
  logic            w_idle;
  logic            w_enter_done;
  logic [AW+1:0]   w_acc_addr;
  logic [31:0]     w_acc_wdata;
  logic [2:0]      w_acc_funct3;
  logic            w_acc_wr;
  logic            w_acc_fault;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load;
  logic [3:0]      w_be;
  logic [31:0]     w_wlane;

  assign w_req  = bus.mem_rd_i | bus.mem_wr_i;
  assign w_idle = (r_state == S_IDLE);

  // Every reason to reject an access is decided from the request as presented in IDLE.
  assign w_in_fault = (bus.mem_rd_i & bus.mem_wr_i)
                    | (bus.funct3_i inside {3'b011, 3'b110, 3'b111})
                    | (bus.mem_wr_i & (bus.funct3_i inside {3'b100, 3'b101}))
                    | ((bus.funct3_i[1:0] == 2'b01) & bus.addr_i[0])
                    | ((bus.funct3_i[1:0] == 2'b10) & (bus.addr_i[1:0] != 2'b00))
                    | ({2'b00, bus.addr_i[31:2]} >= 32'(DEPTH));

  // With zero latency the access happens on the request edge itself, so the
  // datapath reads the live request in IDLE and the latched copy otherwise.
  assign w_acc_addr   = w_idle ? bus.addr_i[AW+1:0] : r_addr;
  assign w_acc_wdata  = w_idle ? bus.wdata_i        : r_wdata;
  assign w_acc_funct3 = w_idle ? bus.funct3_i       : r_funct3;
  assign w_acc_wr     = w_idle ? bus.mem_wr_i       : r_wr;
  assign w_acc_fault  = w_idle ? w_in_fault         : r_fault;

  assign w_enter_done = rst_n_i & ((w_idle & w_req & ZERO_LAT)
                                 | ((r_state == S_BUSY) & (r_cnt == CW'(1))));

  assign w_idx = w_acc_addr[AW+1:2];

  // Load lane selection and sign/zero extension, plus store byte enables.
  always_comb begin
    w_word  = r_mem[w_idx];
    w_byte  = w_word[{w_acc_addr[1:0], 3'b000} +: 8];
    w_half  = w_acc_addr[1] ? w_word[31:16] : w_word[15:0];
    w_load  = w_word;
    w_be    = 4'b1111;
    w_wlane = w_acc_wdata;
    case (w_acc_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = w_word;
    endcase
    case (w_acc_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_acc_addr[1:0];
        w_wlane = {4{w_acc_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_acc_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_acc_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = w_acc_wdata;
      end
    endcase
  end

  // Array write on entry to DONE; contents survive reset by design.
  always_ff @(posedge clk_i) begin
    if (w_enter_done & w_acc_wr & ~w_acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  // Control FSM: latch request in IDLE, count BUSY cycles, pulse result in DONE.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_funct3  <= '0;
      r_wr      <= 1'b0;
      r_fault   <= 1'b0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_fault_p <= 1'b0;
    end else begin
      r_done    <= w_enter_done;
      r_fault_p <= w_enter_done & w_acc_fault;
      if (w_enter_done) begin
        if (w_acc_fault)    r_rdata <= '0;
        else if (!w_acc_wr) r_rdata <= w_load;
      end
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr   <= bus.addr_i[AW+1:0];
            r_wdata  <= bus.wdata_i;
            r_funct3 <= bus.funct3_i;
            r_wr     <= bus.mem_wr_i;
            r_fault  <= w_in_fault;
            r_cnt    <= CW'(LATENCY);
            r_state  <= ZERO_LAT ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_o = rst_n_i & ((w_idle & w_req) | (r_state == S_BUSY));
  assign bus.rdata_o = r_rdata;
  assign bus.done_o  = r_done;
  assign bus.fault_o = r_fault_p;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, multi-cycle corner sequences,
// randomized loads/stores against a byte-array reference model.
// Two instances: LATENCY=2 (sel 0) and LATENCY=0 (sel 1).
module tb_data_mem_ctrl;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        t_sel, t_rd, t_wr;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl_if if_a ();
  data_mem_ctrl_if if_b ();

  assign if_a.mem_rd_i = t_rd & ~t_sel;
  assign if_a.mem_wr_i = t_wr & ~t_sel;
  assign if_a.funct3_i = t_f3;
  assign if_a.addr_i   = t_addr;
  assign if_a.wdata_i  = t_wdata;
  assign if_b.mem_rd_i = t_rd & t_sel;
  assign if_b.mem_wr_i = t_wr & t_sel;
  assign if_b.funct3_i = t_f3;
  assign if_b.addr_i   = t_addr;
  assign if_b.wdata_i  = t_wdata;

  data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(if_a));
  data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(if_b));

  logic        o_stall, o_done, o_fault;
  logic [31:0] o_rdata;
  assign o_stall = t_sel ? if_b.stall_o : if_a.stall_o;
  assign o_done  = t_sel ? if_b.done_o  : if_a.done_o;
  assign o_fault = t_sel ? if_b.fault_o : if_a.fault_o;
  assign o_rdata = t_sel ? if_b.rdata_o : if_a.rdata_o;

  // Reference model: one byte array per instance plus written-byte tracking.
  logic [7:0] mem_m [2][4*DEPTH];
  bit         kn_m  [2][4*DEPTH];

  typedef struct {
    bit          sel;
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rdata;
    bit          exp_fault;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit sel, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] val, output bit flt, output bit known);
    int sz;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    flt = (rd && wr) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)
       || (wr && (f3 == 3'd4 || f3 == 3'd5))
       || (sz == 2 && addr % 2 != 0) || (sz == 4 && addr % 4 != 0)
       || ((addr / 4) >= 32'(DEPTH));
    val   = 32'h0;
    known = 1'b1;
    if (!flt && wr) begin
      for (int i = 0; i < sz; i++) begin
        mem_m[sel][int'(addr) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
        kn_m[sel][int'(addr) + i]  = 1'b1;
      end
    end
    if (!flt && rd) begin
      for (int i = 0; i < sz; i++) begin
        val   = val | (32'(mem_m[sel][int'(addr) + i]) << (8 * i));
        known = known & kn_m[sel][int'(addr) + i];
      end
      if (sz < 4 && !f3[2] && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8 * sz));
    end
  endtask

  // One access on the selected instance; requires the instance to be IDLE.
  task automatic access(input bit sel, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic flt,
                        output int cyc, output int stall_bad);
    bit seen;
    seen = 1'b0; cyc = 0; stall_bad = 0; rdata = 'x; flt = 'x;
    @(negedge clk);
    t_sel = sel; t_rd = rd; t_wr = wr; t_f3 = f3; t_addr = addr; t_wdata = wdata;
    #1;
    if (o_stall !== 1'b1) stall_bad++;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin t_rd = 1'b0; t_wr = 1'b0; end
      #1;
      cyc++;
      if (o_done === 1'b1) begin
        seen  = 1'b1;
        rdata = o_rdata;
        flt   = o_fault;
        if (o_stall !== 1'b0) stall_bad++;
        break;
      end else if (o_stall !== 1'b1) stall_bad++;
    end
    t_rd = 1'b0; t_wr = 1'b0;
    if (seen) @(posedge clk);
  endtask

  task automatic run_op(input bit sel, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rd, output logic got_flt,
                        output logic [31:0] exp_rd, output bit exp_flt, output bit exp_known);
    int cyc, sb;
    model(sel, rd, wr, f3, addr, wdata, exp_rd, exp_flt, exp_known);
    access(sel, rd, wr, f3, addr, wdata, got_rd, got_flt, cyc, sb);
    chk("latency", 32'(cyc), sel ? 32'd1 : 32'd3);
    chk("stall",   32'(sb),  32'd0);
  endtask

  function automatic vec_t mkv(bit sel, bit rd, bit wr, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wdata, bit chk_rd, logic [31:0] er, bit ef);
    vec_t v;
    v.sel = sel; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rdata = er; v.exp_fault = ef;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gr, er;
    logic        gf;
    bit          ef, ek;
    int          dn, pat_bad;
    logic [2:0]  f3_ok [5];
    logic [2:0]  f3_bad [3];
    f3_ok  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    f3_bad = '{3'd3, 3'd6, 3'd7};

    //            sel rd wr f3    addr          wdata         chk expected      flt
    vt.push_back(mkv(0, 0, 1, 3'd2, 32'h10,   32'hDEADBEEF, 0, 32'h0,        0));
    vt.push_back(mkv(0, 1, 0, 3'd2, 32'h10,   32'h0,        1, 32'hDEADBEEF, 0));
    vt.push_back(mkv(0, 0, 1, 3'd0, 32'h11,   32'h00000080, 0, 32'h0,        0));
    vt.push_back(mkv(0, 1, 0, 3'd0, 32'h11,   32'h0,        1, 32'hFFFFFF80, 0));
    vt.push_back(mkv(0, 1, 0, 3'd4, 32'h11,   32'h0,        1, 32'h00000080, 0));
    vt.push_back(mkv(0, 1, 0, 3'd2, 32'h10,   32'h0,        1, 32'hDEAD80EF, 0));
    vt.push_back(mkv(0, 0, 1, 3'd1, 32'h22,   32'h00008001, 0, 32'h0,        0));
    vt.push_back(mkv(0, 1, 0, 3'd1, 32'h22,   32'h0,        1, 32'hFFFF8001, 0));
    vt.push_back(mkv(0, 1, 0, 3'd5, 32'h22,   32'h0,        1, 32'h00008001, 0));
    vt.push_back(mkv(0, 1, 0, 3'd1, 32'h21,   32'h0,        1, 32'h0,        1));
    vt.push_back(mkv(0, 0, 1, 3'd2, 32'h14,   32'h11223344, 0, 32'h0,        0));
    vt.push_back(mkv(0, 0, 1, 3'd2, 32'h13,   32'hAAAAAAAA, 0, 32'h0,        1));
    vt.push_back(mkv(0, 1, 0, 3'd2, 32'h10,   32'h0,        1, 32'hDEAD80EF, 0));
    vt.push_back(mkv(0, 1, 0, 3'd2, 32'h14,   32'h0,        1, 32'h11223344, 0));
    vt.push_back(mkv(0, 0, 1, 3'd2, 32'h1000, 32'h55555555, 0, 32'h0,        1));
    vt.push_back(mkv(0, 1, 0, 3'd2, 32'h1000, 32'h0,        1, 32'h0,        1));
    vt.push_back(mkv(0, 1, 1, 3'd2, 32'h10,   32'h99999999, 1, 32'h0,        1));
    vt.push_back(mkv(0, 1, 0, 3'd3, 32'h10,   32'h0,        1, 32'h0,        1));
    vt.push_back(mkv(0, 0, 1, 3'd4, 32'h10,   32'h00000077, 0, 32'h0,        1));
    vt.push_back(mkv(0, 0, 1, 3'd5, 32'h12,   32'h00007777, 0, 32'h0,        1));
    vt.push_back(mkv(0, 1, 0, 3'd2, 32'h10,   32'h0,        1, 32'hDEAD80EF, 0));
    vt.push_back(mkv(0, 1, 0, 3'd0, 32'h12,   32'h0,        1, 32'hFFFFFFAD, 0));
    vt.push_back(mkv(0, 1, 0, 3'd4, 32'h13,   32'h0,        1, 32'h000000DE, 0));
    vt.push_back(mkv(0, 1, 0, 3'd1, 32'h10,   32'h0,        1, 32'hFFFF80EF, 0));
    vt.push_back(mkv(0, 1, 0, 3'd5, 32'h12,   32'h0,        1, 32'h0000DEAD, 0));
    vt.push_back(mkv(1, 0, 1, 3'd2, 32'h40,   32'h0BADF00D, 0, 32'h0,        0));
    vt.push_back(mkv(1, 1, 0, 3'd2, 32'h40,   32'h0,        1, 32'h0BADF00D, 0));

    // Reset with a request pending: stall must stay low, outputs cleared.
    rst_n = 1'b0; t_sel = 1'b0; t_rd = 1'b1; t_wr = 1'b0; t_f3 = 3'd2;
    t_addr = 32'h10; t_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall_a", 32'(if_a.stall_o), 32'd0);
    chk("rst_done_a",  32'(if_a.done_o),  32'd0);
    chk("rst_fault_a", 32'(if_a.fault_o), 32'd0);
    chk("rst_rdata_a", if_a.rdata_o,      32'h0);
    t_sel = 1'b1; #1;
    chk("rst_stall_b", 32'(if_b.stall_o), 32'd0);
    chk("rst_rdata_b", if_b.rdata_o,      32'h0);
    t_rd = 1'b0; t_sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_done", 32'(if_a.done_o), 32'd0);

    // Directed vector table.
    foreach (vt[i]) begin
      run_op(vt[i].sel, vt[i].rd, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wdata,
             gr, gf, er, ef, ek);
      chk($sformatf("vec%0d_fault", i), 32'(gf), 32'(vt[i].exp_fault));
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), gr, vt[i].exp_rdata);
    end

    // LATENCY=0 back-to-back loads with the request held high.
    @(negedge clk);
    t_sel = 1'b1; t_rd = 1'b1; t_wr = 1'b0; t_f3 = 3'd2; t_addr = 32'h40;
    #1;
    pat_bad = 0; dn = 0;
    if (if_b.stall_o !== 1'b1) pat_bad++;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (if_b.done_o !== 1'(k % 2))   pat_bad++;
      if (if_b.stall_o !== !(k % 2))   pat_bad++;
      if (if_b.done_o === 1'b1) begin
        dn++;
        if (if_b.rdata_o !== 32'h0BADF00D) pat_bad++;
      end
    end
    t_rd = 1'b0;
    chk("b2b_pattern", 32'(pat_bad), 32'd0);
    chk("b2b_dones",   32'(dn),      32'd3);
    @(posedge clk);

    // Reset during BUSY of a store: write dropped, no done pulse.
    run_op(0, 0, 1, 3'd2, 32'h30, 32'hCAFEF00D, gr, gf, er, ef, ek);
    chk("sw30_fault", 32'(gf), 32'd0);
    @(negedge clk);
    t_sel = 1'b0; t_wr = 1'b1; t_f3 = 3'd2; t_addr = 32'h30; t_wdata = 32'h12345678;
    @(posedge clk); #1; t_wr = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_done",  32'(if_a.done_o),  32'd0);
    chk("midrst_stall", 32'(if_a.stall_o), 32'd0);
    chk("midrst_fault", 32'(if_a.fault_o), 32'd0);
    chk("midrst_rdata", if_a.rdata_o,      32'h0);
    @(negedge clk); rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (if_a.done_o === 1'b1) dn++;
    end
    chk("midrst_nodone", 32'(dn), 32'd0);
    run_op(0, 1, 0, 3'd2, 32'h30, 32'h0, gr, gf, er, ef, ek);
    chk("midrst_old", gr, 32'hCAFEF00D);

    // Random traffic against the model on the LATENCY=2 instance.
    for (int w = 0; w < 16; w++) begin
      run_op(0, 0, 1, 3'd2, 32'h100 + 32'(4 * w), $urandom, gr, gf, er, ef, ek);
    end
    for (int n = 0; n < 300; n++) begin
      bit          rrd, rwr;
      logic [2:0]  rf3;
      logic [31:0] ra;
      int          r;
      r = $urandom_range(0, 99);
      rrd = (r < 45) || (r >= 90 && r < 94);
      rwr = (r >= 45);
      if ($urandom_range(0, 9) < 8) rf3 = f3_ok[$urandom_range(0, 4)];
      else                          rf3 = f3_bad[$urandom_range(0, 2)];
      if ($urandom_range(0, 9) < 9) ra = 32'h100 + 32'($urandom_range(0, 63));
      else                          ra = 32'h1000 + 32'($urandom_range(0, 4095));
      run_op(0, rrd, rwr, rf3, ra, $urandom, gr, gf, er, ef, ek);
      chk($sformatf("rnd%0d_fault", n), 32'(gf), 32'(ef));
      if (rrd && ek) chk($sformatf("rnd%0d_rdata", n), gr, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
